// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, synchronous flush,
// read-valid strobe and sticky overflow/underflow flags.
// Depth need not be a power of two; pointers wrap explicitly.
// Optional build macro SYNC_FIFO_FLEX_FWFT_EN selects first-word-fall-through
// output. Without it, reads are registered with one cycle of latency.
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         dataIn,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         dataOut,
  output logic                          dataOut_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_CNT = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT = CW'(AE_LEVEL);

  // Parameter legality is enforced at elaboration time.
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 1024) begin : g_bad_depth
    $error("sync_fifo_flex: FIFO_DEPTH must be in 2..1024");
  end
  if (AF_LEVEL < 0 || AF_LEVEL > FIFO_DEPTH) begin : g_bad_af
    $error("sync_fifo_flex: AF_LEVEL must be in 0..FIFO_DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL >= FIFO_DEPTH) begin : g_bad_ae
    $error("sync_fifo_flex: AE_LEVEL must be in 0..FIFO_DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_en, rd_en, mem_we;

  // Advance a pointer, wrapping at the last legal entry rather than at 2**PW.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Flags decode the registered count so they are glitch-free and aligned.
  assign full         = (count_q == DEPTH_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Full/empty are taken from the pre-edge count, so a same-cycle pop never
  // rescues a push into a full FIFO, nor a push a pop from an empty one.
  assign wr_en  = push && !full;
  assign rd_en  = pop && !empty;
  assign mem_we = wr_en && !clear;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push && full) overflow_d  = 1'b1;
      if (pop && empty) underflow_d = 1'b1;
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; occupancy and
    // pointers define which entries are meaningful, and a reset here would
    // prevent mapping onto RAM.
    if (mem_we) mem_q[wr_ptr_q] <= dataIn;
  end

`ifdef SYNC_FIFO_FLEX_FWFT_EN
  // Head-of-queue word is presented directly; zero while nothing is stored
  // so the output is defined during and right after reset.
  assign dataOut       = empty ? '0 : mem_q[rd_ptr_q];
  assign dataOut_valid = !empty;
`else
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dvalid_q, dvalid_d;

  // Registered read: capture the head word on an accepted pop; flush keeps
  // the last word but drops the strobe.
  always_comb begin
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    if (!clear && rd_en) begin
      dout_d   = mem_q[rd_ptr_q];
      dvalid_d = 1'b1;
    end
  end

  // Read data register; reset also kills a read in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign dataOut       = dout_q;
  assign dataOut_valid = dvalid_q;
`endif

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Parametrised single-clock FIFO that succeeds the fixed 8x8 sync FIFO, for buffering between producer and consumer blocks in one clock domain.
- Width and depth are independent parameters; any depth >= 2 is supported, not only powers of two.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, a read-valid strobe and sticky overflow/underflow error flags.
- Storage, pointers, counter and flag logic are all contained in this one module.

Parameters:
- DATA_WIDTH, 8, bits per word on dataIn/dataOut.
- FIFO_DEPTH, 8, number of entries; legal range 2..1024, power of two not required.
- AF_LEVEL, FIFO_DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset; reset=0 holds the block in reset.
- clear  input  1  synchronous flush; empties the FIFO at the next edge.
- push  input  1  write request.
- dataIn  input  DATA_WIDTH  write data, sampled when the write is accepted.
- pop  input  1  read request.
- dataOut  output  DATA_WIDTH  read data.
- dataOut_valid  output  1  dataOut holds a newly read word.
- full  output  1  count == FIFO_DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
- overflow  output  1  sticky: a push was seen while full.
- underflow  output  1  sticky: a pop was seen while empty.

Behaviour:
- Reset: while reset=0, asynchronously set pointers=0, count=0, dataOut=0, dataOut_valid=0, overflow=0, underflow=0. Consequently empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0).
- Storage contents are not reset.
- Write accept: wr_en = push && !full. Full is evaluated before any same-cycle pop, so a push while full is dropped even if a pop occurs in that cycle.
- Read accept: rd_en = pop && !empty. Empty is evaluated before any same-cycle push, so a pop while empty is refused even if a push occurs in that cycle.
- Pointers: each pointer is $clog2(FIFO_DEPTH) bits. It increments on its enable and wraps from FIFO_DEPTH-1 to 0 explicitly; no power-of-two wrap is relied on.
- Count update:
  - +1 on wr_en only.
  - -1 on rd_en only.
  - unchanged when both or neither are active.
- Flags are combinational decodes of the registered count; they are valid one cycle after the accepting edge.
- Read latency (standard mode):
  - On an edge where rd_en=1, dataOut takes mem[rd_ptr] and dataOut_valid=1 for exactly one cycle.
  - Otherwise dataOut holds its last value and dataOut_valid=0.
- Simultaneous push and pop when 0 < count < FIFO_DEPTH: both accepted, count unchanged.
- Write-to-read: a word written at edge N is readable by a pop presented in cycle N+1 or later.
- Errors:
  - overflow sets on push && full; underflow sets on pop && empty.
  - Both are sticky until reset or clear; no state other than these flags changes.
- clear (synchronous, takes priority over push and pop in the same cycle):
  - pointers=0, count=0, overflow=0, underflow=0, dataOut_valid=0.
  - dataOut holds its value.
- Reset mid-operation: everything returns to reset values immediately, including a read in flight (dataOut_valid drops asynchronously).
- Illegal parameters: AF_LEVEL > FIFO_DEPTH or AE_LEVEL >= FIFO_DEPTH is stopped by an elaboration-time $error.

Optional Feature:
- SYNC_FIFO_FLEX_FWFT_EN defined: first-word-fall-through mode.
  - dataOut continuously presents mem[rd_ptr]; dataOut_valid = !empty.
  - pop consumes the presented word; the next word, if any, appears the cycle after the accepting edge.
  - A word written into an empty FIFO appears on dataOut one cycle after its write edge.
  - Flags, count and error rules are unchanged.
- Undefined: the standard one-cycle registered read described above.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release -> empty=1, full=0, count=0, dataOut=0, dataOut_valid=0, overflow=0, underflow=0.
- Fill/drain with DEPTH=8: push 0x01..0x08 -> full=1, count=8, almost_full set at count 6. Pop 8 -> dataOut 0x01..0x08 in order, each with a one-cycle dataOut_valid pulse; then empty=1.
- Non-power-of-two wrap with DEPTH=5: push 3, pop 3, push 5, pop 5 -> data order preserved across the pointer wrap 4->0; count peaks at 5 with full=1.
- Simultaneous push and pop at count=4 (DEPTH=8) for 10 cycles -> count stays 4, output is the in-order stream.
- Push and pop at the boundaries:
  - Push while full with pop=1 -> push dropped, overflow=1, count drops to 7.
  - Pop while empty with push=1 -> pop refused, underflow=1, count rises to 1.
  - clear -> count=0, both error flags=0.
- With SYNC_FIFO_FLEX_FWFT_EN: push 0xA5 into the empty FIFO -> next cycle dataOut=0xA5, dataOut_valid=1 with no pop. Pop -> empty=1, dataOut_valid=0 on the following cycle.
